// File: rtl/otbn_wdr_readout.sv
// Streams a range of wide data registers out as 39-bit integrity-protected granules.
// One WDR is read per LOAD cycle into a buffer, then handed out granule by granule.
module otbn_wdr_readout #(
  parameter int WdrAw            = 5,
  parameter int NWdr             = 32,
  parameter int BaseIntgWidth    = 39,
  parameter int BaseWordsPerWLEN = 8,
  localparam int ExtWLEN         = BaseIntgWidth * BaseWordsPerWLEN
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [WdrAw-1:0]         start_addr_i,
  input  logic [WdrAw:0]           num_regs_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [WdrAw-1:0]         rd_addr_o,
  input  logic [ExtWLEN-1:0]       rd_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [BaseIntgWidth-1:0] out_data_o,
  output logic                     out_last_o
);

  localparam int IdxW = (BaseWordsPerWLEN > 1) ? $clog2(BaseWordsPerWLEN) : 1;
  localparam logic [IdxW-1:0]  LastWord = IdxW'(BaseWordsPerWLEN - 1);
  localparam logic [WdrAw-1:0] LastAddr = WdrAw'(NWdr - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WdrAw-1:0]   cur_addr_q, cur_addr_d;
  logic [WdrAw:0]     remaining_q, remaining_d;
  logic [IdxW-1:0]    word_idx_q, word_idx_d;
  logic [ExtWLEN-1:0] buf_q, buf_d;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    word_idx_d  = word_idx_q;
    buf_d       = buf_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (num_regs_i != '0) begin
            cur_addr_d  = start_addr_i;
            remaining_d = num_regs_i;
            state_d     = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          buf_d       = rd_data_i;
          word_idx_d  = '0;
          remaining_d = remaining_q - 1'b1;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        // Abort wins over a transfer that would otherwise happen this cycle.
        if (abort_i) begin
          state_d = IDLE;
        end else if (out_ready_i) begin
          if (word_idx_q == LastWord) begin
            if (remaining_q != '0) begin
              cur_addr_d = (cur_addr_q == LastAddr) ? '0 : cur_addr_q + 1'b1;
              state_d    = LOAD;
            end else begin
              state_d = DONE;
            end
          end else begin
            word_idx_d = word_idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      word_idx_q  <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      word_idx_q  <= word_idx_d;
      buf_q       <= buf_d;
    end
  end

  // Outputs decode flopped state only, so they drop as soon as reset asserts.
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign rd_addr_o   = cur_addr_q;
  assign out_valid_o = (state_q == STREAM);
  assign out_data_o  = buf_q[BaseIntgWidth * 32'(word_idx_q) +: BaseIntgWidth];
  assign out_last_o  = (state_q == STREAM) && (word_idx_q == LastWord) &&
                       (remaining_q == '0);

endmodule

// File: doc/otbn_wdr_readout.md
OTBN_WDR_READOUT -- requirements
Module: otbn_wdr_readout

Interface
REQ-001 The block SHALL have parameter WdrAw, default 5, meaning WDR address width.
REQ-002 The block SHALL have parameter NWdr, default 32, meaning number of WDRs.
REQ-003 The block SHALL have parameter BaseIntgWidth, default 39, meaning one 32b data granule plus 7b integrity.
REQ-004 The block SHALL have parameter BaseWordsPerWLEN, default 8, meaning granules per WDR; ExtWLEN = BaseIntgWidth*BaseWordsPerWLEN = 312.
REQ-005 Port clk_i  input  1  single clock, rising edge.
REQ-006 Port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 Port start_i  input  1  request a dump; sampled only in IDLE.
REQ-008 Port abort_i  input  1  cancel an active dump.
REQ-009 Port start_addr_i  input  WdrAw  first WDR to read.
REQ-010 Port num_regs_i  input  WdrAw+1  number of WDRs to dump, 0..NWdr.
REQ-011 Port busy_o  output  1  high in any state other than IDLE.
REQ-012 Port done_o  output  1  one-cycle pulse on normal completion.
REQ-013 Port rd_addr_o  output  WdrAw  address to the register-file read port (asynchronous read).
REQ-014 Port rd_data_i  input  ExtWLEN  register-file read data for rd_addr_o, valid in the same cycle.
REQ-015 Port out_valid_o  output  1  output granule valid.
REQ-016 Port out_ready_i  input  1  consumer accepts the granule.
REQ-017 Port out_data_o  output  BaseIntgWidth  granule, integrity bits passed through unmodified.
REQ-018 Port out_last_o  output  1  high with the final granule of the dump.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, STREAM and DONE.
REQ-020 IDLE: on start_i=1 with num_regs_i>0, latch cur_addr=start_addr_i and remaining=num_regs_i, then go to LOAD; with num_regs_i=0, go to DONE.
REQ-021 LOAD: drive rd_addr_o=cur_addr, capture rd_data_i into a 312b buffer, set word_idx=0, decrement remaining, then go to STREAM (exactly one cycle).
REQ-022 STREAM: out_valid_o=1 and out_data_o=buffer[word_idx*39 +: 39]; a transfer occurs when out_valid_o and out_ready_i are both high.
REQ-023 On a transfer with word_idx<7, word_idx SHALL increment and the FSM SHALL stay in STREAM.
REQ-024 On a transfer with word_idx=7, the FSM SHALL go to LOAD with cur_addr+1 (wrap NWdr-1 -> 0) if remaining>0, else go to DONE.
REQ-025 out_data_o and out_last_o SHALL be held stable while out_valid_o=1 and out_ready_i=0.
REQ-026 out_last_o SHALL be 1 only when in STREAM with word_idx=7 and remaining=0.
REQ-027 DONE: done_o=1 for exactly one cycle, then go to IDLE.
REQ-028 abort_i=1 in LOAD or STREAM SHALL force IDLE on the next edge with no done_o and no further transfers; abort_i SHALL take priority over a simultaneous transfer.
REQ-029 start_i SHALL be ignored in every state except IDLE.
REQ-030 rd_addr_o SHALL equal cur_addr in all states; out_valid_o SHALL be 0 outside STREAM.
REQ-031 Latency: start_i at cycle 0 -> LOAD at cycle 1 -> first out_valid_o at cycle 2; each WDR costs 1 LOAD cycle plus 8 transfers.

Reset
REQ-032 While rst_i=1, asynchronously: state=IDLE, busy_o=0, done_o=0, out_valid_o=0, out_last_o=0, rd_addr_o=0, word_idx=0, remaining=0, buffer=0.
REQ-033 Reset asserted mid-dump SHALL abandon the dump with no done_o pulse.

Verification
REQ-034 start_addr=3, num_regs=1, out_ready_i always 1 -> rd_addr_o=3 at cycle 1, granules 0..7 of WDR3 on cycles 2..9, out_last_o at cycle 9, done_o at cycle 10.
REQ-035 start_addr=31, num_regs=2 -> WDR31 then WDR0 (wrap), 16 granules total, exactly one done_o pulse.
REQ-036 out_ready_i toggles pseudo-randomly -> granules arrive in order with no loss or duplication, and data is stable during stalls.
REQ-037 num_regs=0 -> done_o one cycle after start_i, out_valid_o never asserted.
REQ-038 abort_i at granule 4 with out_ready_i=1 -> IDLE next cycle, no done_o, no 5th transfer; a new start_i is then accepted.
REQ-039 rst_i pulsed during STREAM -> all outputs reach their REQ-032 values immediately, without waiting for a clock edge.
